// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared types and constants for the serial pattern transmitter.
//   tx_state_t      : FSM state encoding of pattern_tx_fsm
//   IDLE_LEVEL_DEF  : default line level while no pattern bit is driven
//   calc_len_w()    : width needed to hold a length of 0..width
// -----------------------------------------------------------------------------
package pattern_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } tx_state_t;

   localparam logic IDLE_LEVEL_DEF = 1'b1;

   function automatic int calc_len_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/pattern_shreg.sv
// -----------------------------------------------------------------------------
// pattern_shreg
// Left-shifting pattern register with parallel load and zero fill.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset (clears)
//   i_load     : load i_din (has priority over i_shift)
//   i_shift    : shift left by one, zero into bit 0
//   i_din      : parallel load value
//   o_msb      : current MSB (bit being transmitted)
//   o_nxt      : bit that becomes MSB after the next shift
// -----------------------------------------------------------------------------
module pattern_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_din,
   output logic             o_msb,
   output logic             o_nxt
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_din;
      end else if (i_shift) begin
         r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
   end

   assign o_msb = r_q[WIDTH-1];
   assign o_nxt = r_q[WIDTH-2];

endmodule

// File: rtl/pattern_tx_fsm.sv
// -----------------------------------------------------------------------------
// pattern_tx_fsm
// Serial pattern transmitter (Moore FSM). Captures up to WIDTH bits on start,
// shifts them out MSB-first one per clock, optionally repeating the pattern
// with a one-cycle idle gap between repetitions.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   start      : transfer request, accepted only while ready=1
//   pattern    : bits to send; bit len-1 first, bit 0 last
//   len        : number of bits to send, clamped to WIDTH
//   repeat_n   : extra repetitions (total sends = repeat_n+1)
//   abort      : synchronous cancel while shifting or in the gap
//   ready      : idle, start will be accepted
//   a          : serial data (IDLE_LEVEL when no bit is driven)
//   valid      : a carries a pattern bit this cycle
//   done       : one-cycle pulse at normal completion
// -----------------------------------------------------------------------------
module pattern_tx_fsm
   import pattern_pkg::*;
#(
   parameter  int   WIDTH      = 8,
   parameter  int   REPEAT_W   = 4,
   parameter  logic IDLE_LEVEL = IDLE_LEVEL_DEF,
   localparam int   LEN_W      = calc_len_w(WIDTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [WIDTH-1:0]    pattern,
   input  logic [LEN_W-1:0]    len,
   input  logic [REPEAT_W-1:0] repeat_n,
   input  logic                abort,
   output logic                ready,
   output logic                a,
   output logic                valid,
   output logic                done
);

   tx_state_t           r_state;
   logic                r_ready;
   logic                r_a;
   logic                r_valid;
   logic                r_done;
   logic [LEN_W-1:0]    r_bit_cnt;
   logic [LEN_W-1:0]    r_len_cap;
   logic [REPEAT_W-1:0] r_rep_cnt;
   logic [WIDTH-1:0]    r_pat_cap;

   logic [LEN_W-1:0]    w_eff_len;
   logic [WIDTH-1:0]    w_just;
   logic                w_idle;
   logic                w_in_shift;
   logic                w_last;
   logic                w_reload;
   logic                w_shift_en;
   logic                w_load_en;
   logic [WIDTH-1:0]    w_load_val;
   logic                w_msb;
   logic                w_nxt;

   // Clamp length, then left-justify so the first bit to send sits at the MSB.
   assign w_eff_len  = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
   assign w_just     = pattern << (LEN_W'(WIDTH) - w_eff_len);

   assign w_idle     = (r_state == S_IDLE);
   assign w_in_shift = (r_state == S_SHIFT);
   assign w_last     = (r_bit_cnt == '0);
   assign w_reload   = w_in_shift & ~abort & w_last & (r_rep_cnt != '0);
   assign w_shift_en = w_in_shift & ~abort & ~w_last;
   assign w_load_en  = (w_idle & start) | w_reload;
   // A fresh start loads from the inputs; a repetition reloads the captured copy.
   assign w_load_val = w_idle ? w_just : r_pat_cap;

   pattern_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load_en),
      .i_shift (w_shift_en),
      .i_din   (w_load_val),
      .o_msb   (w_msb),
      .o_nxt   (w_nxt)
   );

   // Outputs are registered for the state being entered, so r_a must carry
   // the bit that will sit at the shift register MSB after this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_a       <= IDLE_LEVEL;
         r_valid   <= 1'b0;
         r_done    <= 1'b0;
         r_bit_cnt <= '0;
         r_len_cap <= '0;
         r_rep_cnt <= '0;
         r_pat_cap <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_pat_cap <= w_just;
                  r_len_cap <= w_eff_len;
                  r_rep_cnt <= repeat_n;
                  r_bit_cnt <= w_eff_len - LEN_W'(1);
                  r_ready   <= 1'b0;
                  if (w_eff_len != '0) begin
                     r_state <= S_SHIFT;
                     r_valid <= 1'b1;
                     r_a     <= w_just[WIDTH-1];
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_valid <= 1'b0;
                  r_a     <= IDLE_LEVEL;
               end else if (!w_last) begin
                  r_bit_cnt <= r_bit_cnt - LEN_W'(1);
                  r_a       <= w_nxt;
               end else if (r_rep_cnt != '0) begin
                  r_rep_cnt <= r_rep_cnt - REPEAT_W'(1);
                  r_bit_cnt <= r_len_cap - LEN_W'(1);
                  r_state   <= S_GAP;
                  r_valid   <= 1'b0;
                  r_a       <= IDLE_LEVEL;
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_valid <= 1'b0;
                  r_a     <= IDLE_LEVEL;
               end
            end
            S_GAP: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  // Shift register was reloaded on entry to the gap.
                  r_state <= S_SHIFT;
                  r_valid <= 1'b1;
                  r_a     <= w_msb;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
               r_done  <= 1'b0;
               r_a     <= IDLE_LEVEL;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign a     = r_a;
   assign valid = r_valid;
   assign done  = r_done;

endmodule

// File: doc/pattern_tx_fsm.md
Name: pattern_tx_fsm

Overview:
Serial pattern transmitter. It is the drive side of the team's serial sequence detectors.
- Captures a programmable bit pattern of up to WIDTH bits on a start handshake.
- Shifts it out MSB-first, one bit per clock, as a Moore FSM.
- Optionally repeats the pattern, with a one-cycle idle gap between repetitions.
- Used as the bit source for detector benches and on-chip loopback self-test.

Parameters:
WIDTH, 8, maximum pattern length in bits (≥2)
REPEAT_W, 4, width of repeat count
IDLE_LEVEL, 1'b1, level driven on a while not shifting
LEN_W, $clog2(WIDTH)+1, derived width of len (localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
start  in  1  request; accepted only when ready=1
pattern  in  WIDTH  bits to send; bit len-1 is sent first, bit 0 last
len  in  LEN_W  number of bits to send; clamped to WIDTH
repeat_n  in  REPEAT_W  extra repetitions; total sends = repeat_n+1
abort  in  1  synchronous cancel of a transfer in progress
ready  out  1  block idle, start will be accepted
a  out  1  serial data
valid  out  1  a carries a pattern bit this cycle
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset values: all outputs and internal registers are set asynchronously.
  - state=S_IDLE, ready=1, a=IDLE_LEVEL, valid=0, done=0.
  - Shift register and counters = 0.
- Outputs are Moore: decoded only from state and registered datapath. There is no combinational path from any input to any output.
- States: S_IDLE, S_SHIFT, S_GAP, S_DONE.
- S_IDLE: ready=1, valid=0, a=IDLE_LEVEL.
  - start=1 captures pattern, eff_len=min(len,WIDTH) and repeat_n.
  - Shift register loads pattern<<(WIDTH-eff_len), i.e. left-justified.
  - bit_cnt=eff_len-1, rep_cnt=repeat_n.
  - eff_len≠0 → S_SHIFT. eff_len=0 → S_DONE (no bits sent).
- S_SHIFT: ready=0, valid=1, a=shreg[WIDTH-1]. Each clock shifts left with zero fill and decrements bit_cnt.
  - bit_cnt=0 and rep_cnt=0 → S_DONE.
  - bit_cnt=0 and rep_cnt≠0 → rep_cnt−1, reload shreg and bit_cnt from the captured values, → S_GAP.
- S_GAP: exactly one cycle. ready=0, valid=0, a=IDLE_LEVEL; → S_SHIFT.
- S_DONE: exactly one cycle. done=1, ready=0, valid=0, a=IDLE_LEVEL; → S_IDLE.
- Latency:
  - start sampled at edge k → first bit on a in cycle k+1.
  - An L-bit single send → done in cycle k+L+1, ready=1 in cycle k+L+2.
  - With R repeats → done in cycle k+(R+1)·L+R+1.
- start while ready=0 is ignored, not queued. Changes to pattern/len/repeat_n after capture have no effect.
- abort=1 in S_SHIFT or S_GAP → S_IDLE next cycle with no done pulse. abort in S_IDLE or S_DONE is ignored.
- abort and start in the same cycle in S_IDLE: start wins.
- Asynchronous reset mid-transfer returns to the reset values immediately, with no done pulse. The next start operates normally.
- Illegal state encoding → S_IDLE (default branch).

Decomposition:
- Package pattern_pkg holds:
  - typedef enum logic [1:0] tx_state_t {S_IDLE, S_SHIFT, S_GAP, S_DONE}
  - default IDLE_LEVEL constant
  - LEN_W helper function
- One natural sub-module, pattern_shreg: parameterised WIDTH; load/shift enables; MSB out; zero fill.
- The FSM, counters and clamping stay in pattern_tx_fsm.

Test Plan:
1. WIDTH=8, pattern=8'h01, len=2, repeat_n=0, start at cycle 0.
   - a/valid = 0/1 in cycle 1, 1/1 in cycle 2.
   - done=1 in cycle 3, ready=1 in cycle 4.
   - A loopback 01-detector model flags exactly once.
2. pattern=8'hA5, len=8, repeat_n=2.
   - Bits 10100101 in cycles 1–8, 10–17 and 19–26.
   - valid=0 with a=1 in cycles 9 and 18.
   - done in cycle 27 only.
3. During test 2: pulse start at cycle 5 and change pattern to 8'hFF at cycle 6 → bit stream unchanged, no second transfer.
4. len=8, abort at cycle 4 → cycle 5 shows ready=1, valid=0, a=1; done never asserts. A start at cycle 6 sends the full pattern.
5. len=0 → done in cycle 1, valid never high. len=12 with pattern=8'hC3 → 8 bits 11000011, i.e. clamped.
6. Async reset asserted mid-S_SHIFT (between edges) → outputs reach reset values before the next edge, no done. After release, test 1 passes.
